// File: rtl/asip_pkg.sv
// Shared types and encodings for the vector ASIP pipeline.
package asip_pkg;

  typedef enum logic [1:0] {
    StBoot,
    StRun,
    StStall,
    StFlush
  } fetch_state_t;

  localparam logic [3:0] OP_JE  = 4'h8;
  localparam logic [3:0] OP_JNE = 4'h9;
  localparam logic [3:0] OP_JMP = 4'hA;

  localparam logic [2:0] PCWE_JMP = 3'b100;
  localparam logic [2:0] PCWE_JE  = 3'b010;
  localparam logic [2:0] PCWE_JNE = 3'b001;

endpackage

// File: rtl/branch_resolve.sv
// Combinational branch decision: taken flag and absolute target from the one-hot redirect request.
module branch_resolve
  import asip_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic [2:0]        PcWriteEn,
  input  logic              zero_i,
  input  logic [ADDR_W-1:0] Immediate,
  output logic              taken_o,
  output logic [ADDR_W-1:0] target_o
);

  logic is_jmp, is_je, is_jne;

  always_comb begin
    is_jmp   = (PcWriteEn & PCWE_JMP) != 3'b000;
    is_je    = (PcWriteEn & PCWE_JE) != 3'b000;
    is_jne   = (PcWriteEn & PCWE_JNE) != 3'b000;
    taken_o  = is_jmp | (is_je & zero_i) | (is_jne & ~zero_i);
    target_o = Immediate;
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, drives the synchronous instruction memory and presents one
// instruction per cycle, with a one-cycle bubble after taken branches and a hold on stall.
module fetch_stage
  import asip_pkg::*;
#(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned INSTR_W  = 16,
  parameter int unsigned RESET_PC = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall_i,
  input  logic [2:0]         PcWriteEn,
  input  logic [ADDR_W-1:0]  Immediate,
  input  logic               zero_i,
  output logic [ADDR_W-1:0]  imem_addr_o,
  input  logic [INSTR_W-1:0] imem_rdata_i,
  output logic [INSTR_W-1:0] instr_o,
  output logic               valid_o,
  output logic [ADDR_W-1:0]  pc_o,
  output logic               flush_o
);

  localparam logic [ADDR_W-1:0] ResetPc = ADDR_W'(RESET_PC);
  localparam logic [ADDR_W-1:0] PcOne   = ADDR_W'(1);

  fetch_state_t        state_q;
  logic [ADDR_W-1:0]   pc_q, fpc_q, hold_pc_q;
  logic [INSTR_W-1:0]  hold_q;
  logic                valid_q, flush_q;
  logic                br_taken;
  logic [ADDR_W-1:0]   br_target;
  logic                redirect;

  branch_resolve #(
    .ADDR_W(ADDR_W)
  ) u_branch_resolve (
    .PcWriteEn(PcWriteEn),
    .zero_i   (zero_i),
    .Immediate(Immediate),
    .taken_o  (br_taken),
    .target_o (br_target)
  );

  // Only RUN and STALL present a valid slot, so the valid qualifier is implied by the state.
  assign redirect = br_taken & ~stall_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StBoot;
      pc_q      <= ResetPc;
      fpc_q     <= ResetPc;
      hold_q    <= '0;
      hold_pc_q <= '0;
      valid_q   <= 1'b0;
      flush_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StBoot, StFlush: begin
          pc_q    <= pc_q + PcOne;
          fpc_q   <= pc_q;
          state_q <= StRun;
          valid_q <= 1'b1;
          flush_q <= 1'b0;
        end
        StRun, StStall: begin
          if (redirect) begin
            pc_q    <= br_target;
            state_q <= StFlush;
            valid_q <= 1'b0;
            flush_q <= 1'b1;
          end else if (stall_i) begin
            // Capture only on entry; while stalled the memory already returns the successor.
            if (state_q == StRun) begin
              hold_q    <= imem_rdata_i;
              hold_pc_q <= fpc_q;
            end
            state_q <= StStall;
          end else begin
            pc_q    <= pc_q + PcOne;
            fpc_q   <= pc_q;
            state_q <= StRun;
          end
        end
      endcase
    end
  end

  always_comb begin
    instr_o     = '0;
    pc_o        = '0;
    valid_o     = valid_q;
    flush_o     = flush_q;
    imem_addr_o = pc_q;
    if (valid_q) begin
      if (state_q == StStall) begin
        instr_o = hold_q;
        pc_o    = hold_pc_q;
      end else begin
        instr_o = imem_rdata_i;
        pc_o    = fpc_q;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed vector table, wrap check, random vs. reference model.
module tb_fetch_stage;

  logic        clk;
  logic        rst, stall, zero;
  logic [2:0]  pcwe;
  logic [7:0]  imm;
  logic [7:0]  addr;
  logic [15:0] rdata, instr;
  logic        valid, flush;
  logic [7:0]  pc;

  logic        w_rst;
  logic        w_stall, w_zero;
  logic [2:0]  w_pcwe;
  logic [7:0]  w_imm;
  logic [7:0]  w_addr;
  logic [15:0] w_rdata, w_instr;
  logic        w_valid, w_flush;
  logic [7:0]  w_pc;

  logic [15:0] mem [256];

  int n_pass  = 0;
  int n_total = 0;

  fetch_stage #(
    .ADDR_W(8), .INSTR_W(16), .RESET_PC(0)
  ) dut (
    .clk(clk), .rst(rst), .stall_i(stall), .PcWriteEn(pcwe), .Immediate(imm), .zero_i(zero),
    .imem_addr_o(addr), .imem_rdata_i(rdata), .instr_o(instr), .valid_o(valid), .pc_o(pc),
    .flush_o(flush)
  );

  fetch_stage #(
    .ADDR_W(8), .INSTR_W(16), .RESET_PC(254)
  ) dut_wrap (
    .clk(clk), .rst(w_rst), .stall_i(w_stall), .PcWriteEn(w_pcwe), .Immediate(w_imm),
    .zero_i(w_zero), .imem_addr_o(w_addr), .imem_rdata_i(w_rdata), .instr_o(w_instr),
    .valid_o(w_valid), .pc_o(w_pc), .flush_o(w_flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    rdata   <= mem[addr];
    w_rdata <= mem[w_addr];
  end

  typedef struct {
    logic        rst;
    logic        stall;
    logic [2:0]  pcwe;
    logic [7:0]  imm;
    logic        zero;
    logic        ev;
    logic        ef;
    logic [15:0] ei;
    logic [7:0]  ep;
    logic [7:0]  ea;
  } vec_t;

  vec_t tbl [25];

  function automatic vec_t mk(input logic r, input logic s, input logic [2:0] w,
                              input logic [7:0] im, input logic z, input logic ev,
                              input logic ef, input logic [15:0] ei, input logic [7:0] ep,
                              input logic [7:0] ea);
    vec_t v;
    v.rst = r; v.stall = s; v.pcwe = w; v.imm = im; v.zero = z;
    v.ev = ev; v.ef = ef; v.ei = ei; v.ep = ep; v.ea = ea;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Reference model: what the decoder should see, in terms of presented PC only.
  int         m_mode;  // 0: boot/reset slot, 1: branch bubble, 2: presenting m_pc
  logic [7:0] m_pc, m_tgt;
  bit         m_known;

  task automatic model_step();
    bit tk;
    if (rst) begin
      m_mode  = 0;
      m_known = 1;
    end else if (m_known) begin
      case (m_mode)
        0: begin m_mode = 2; m_pc = 8'd0; end
        1: begin m_mode = 2; m_pc = m_tgt; end
        default: begin
          tk = !stall && (pcwe[2] || (pcwe[1] && zero) || (pcwe[0] && !zero));
          if (tk) begin
            m_mode = 1;
            m_tgt  = imm;
          end else if (!stall) begin
            m_pc = m_pc + 8'd1;
          end
        end
      endcase
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = {8'hC0, 8'(i)};
    mem[0]  = 16'hF510; mem[1]  = 16'hA015; mem[2]  = 16'h1370;
    mem[21] = 16'h7E00; mem[22] = 16'h8010; mem[23] = 16'h9032;

    rst = 1'b1; stall = 1'b0; pcwe = 3'b000; imm = 8'd0; zero = 1'b0;
    w_rst = 1'b1; w_stall = 1'b0; w_pcwe = 3'b000; w_imm = 8'd0; w_zero = 1'b0;
    m_mode = 0; m_pc = 8'd0; m_tgt = 8'd0; m_known = 0;

    //               rst stall pcwe    imm  z   v  f  instr     pc   addr
    tbl[0]  = mk(1, 0, 3'b000, 0,  0,  0, 0, 16'h0000, 0,  0);
    tbl[1]  = mk(0, 0, 3'b000, 0,  0,  0, 0, 16'h0000, 0,  0);
    tbl[2]  = mk(0, 0, 3'b000, 0,  0,  1, 0, 16'hF510, 0,  1);
    tbl[3]  = mk(0, 0, 3'b100, 21, 0,  1, 0, 16'hA015, 1,  2);
    tbl[4]  = mk(0, 0, 3'b000, 0,  0,  0, 1, 16'h0000, 0,  21);
    tbl[5]  = mk(0, 0, 3'b000, 0,  0,  1, 0, 16'h7E00, 21, 22);
    tbl[6]  = mk(0, 0, 3'b010, 0,  0,  1, 0, 16'h8010, 22, 23);
    tbl[7]  = mk(0, 0, 3'b001, 50, 0,  1, 0, 16'h9032, 23, 24);
    tbl[8]  = mk(0, 0, 3'b000, 0,  0,  0, 1, 16'h0000, 0,  50);
    tbl[9]  = mk(0, 0, 3'b000, 0,  0,  1, 0, 16'hC032, 50, 51);
    tbl[10] = mk(1, 0, 3'b000, 0,  0,  1, 0, 16'hC033, 51, 52);
    tbl[11] = mk(0, 0, 3'b000, 0,  0,  0, 0, 16'h0000, 0,  0);
    tbl[12] = mk(0, 1, 3'b000, 0,  0,  1, 0, 16'hF510, 0,  1);
    tbl[13] = mk(0, 1, 3'b000, 0,  0,  1, 0, 16'hF510, 0,  1);
    tbl[14] = mk(0, 1, 3'b000, 0,  0,  1, 0, 16'hF510, 0,  1);
    tbl[15] = mk(0, 0, 3'b000, 0,  0,  1, 0, 16'hF510, 0,  1);
    tbl[16] = mk(0, 1, 3'b100, 21, 0,  1, 0, 16'hA015, 1,  2);
    tbl[17] = mk(0, 1, 3'b100, 21, 0,  1, 0, 16'hA015, 1,  2);
    tbl[18] = mk(0, 0, 3'b100, 21, 0,  1, 0, 16'hA015, 1,  2);
    tbl[19] = mk(0, 0, 3'b000, 0,  0,  0, 1, 16'h0000, 0,  21);
    tbl[20] = mk(0, 0, 3'b000, 0,  0,  1, 0, 16'h7E00, 21, 22);
    tbl[21] = mk(0, 0, 3'b100, 2,  0,  1, 0, 16'h8010, 22, 23);
    tbl[22] = mk(1, 0, 3'b000, 0,  0,  0, 1, 16'h0000, 0,  2);
    tbl[23] = mk(0, 0, 3'b000, 0,  0,  0, 0, 16'h0000, 0,  0);
    tbl[24] = mk(0, 0, 3'b000, 0,  0,  1, 0, 16'hF510, 0,  1);

    next_cycle();
    for (int i = 0; i < 25; i++) begin
      rst = tbl[i].rst; stall = tbl[i].stall; pcwe = tbl[i].pcwe;
      imm = tbl[i].imm; zero = tbl[i].zero;
      @(negedge clk);
      chk($sformatf("vec%0d valid", i), valid, tbl[i].ev);
      chk($sformatf("vec%0d flush", i), flush, tbl[i].ef);
      chk($sformatf("vec%0d instr", i), instr, tbl[i].ei);
      chk($sformatf("vec%0d pc", i), pc, tbl[i].ep);
      chk($sformatf("vec%0d imem_addr", i), addr, tbl[i].ea);
      next_cycle();
    end

    // PC wrap from RESET_PC = 254
    mem[254] = 16'hC0FE; mem[255] = 16'hC0FF;
    rst = 1'b1; pcwe = 3'b000; stall = 1'b0; w_rst = 1'b0;
    @(negedge clk);
    chk("wrap boot valid", w_valid, 0);
    chk("wrap boot addr", w_addr, 254);
    next_cycle();
    @(negedge clk);
    chk("wrap pc254", w_pc, 254);
    chk("wrap instr254", w_instr, 16'hC0FE);
    next_cycle();
    @(negedge clk);
    chk("wrap pc255", w_pc, 255);
    chk("wrap instr255", w_instr, 16'hC0FF);
    next_cycle();
    @(negedge clk);
    chk("wrap pc0", w_pc, 0);
    chk("wrap instr0", w_instr, 16'hF510);
    chk("wrap valid0", w_valid, 1);
    next_cycle();

    // Randomized run against the reference model
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    for (int c = 0; c < 1500; c++) begin
      int r;
      rst   = (c == 0) || ($urandom_range(0, 63) == 0);
      stall = ($urandom_range(0, 3) == 0);
      zero  = 1'($urandom_range(0, 1));
      imm   = 8'($urandom);
      r     = int'($urandom_range(0, 5));
      case (r)
        3:       pcwe = 3'b100;
        4:       pcwe = 3'b010;
        5:       pcwe = 3'b001;
        default: pcwe = 3'b000;
      endcase
      @(negedge clk);
      if (m_known) begin
        chk($sformatf("rnd%0d valid", c), valid, (m_mode == 2) ? 1 : 0);
        chk($sformatf("rnd%0d flush", c), flush, (m_mode == 1) ? 1 : 0);
        chk($sformatf("rnd%0d instr", c), instr, (m_mode == 2) ? mem[m_pc] : 16'h0000);
        chk($sformatf("rnd%0d pc", c), pc, (m_mode == 2) ? m_pc : 8'd0);
      end
      model_step();
      next_cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage of the vector ASIP pipeline. It owns the program counter, drives the synchronous instruction memory, and presents one 16-bit instruction per cycle with a valid flag to the decoder. It resolves `PcWriteEn` redirects (jmp, je, jne) against the zero flag, inserts a one-cycle bubble after each taken branch, and holds the presented instruction while the hazard unit stalls.

## Interface
- `ADDR_W`, 8: PC and instruction-memory address width; matches the 8-bit `Immediate` field.
- `INSTR_W`, 16: instruction width.
- `RESET_PC`, 0: first fetch address after reset.

Ports (synchronous active-high reset, single clock):
- `clk` in 1: clock, all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `stall_i` in 1: hazard unit holds the decode slot; acted on only when `valid_o` = 1.
- `PcWriteEn` in 3: one-hot redirect request from decode. `3'b100` = jmp, `3'b010` = je, `3'b001` = jne, `0` = none.
- `Immediate` in ADDR_W: absolute branch target, taken from `instr[7:0]`.
- `zero_i` in 1: Z flag from the NZ flag register.
- `imem_addr_o` out ADDR_W: instruction-memory read address, driven from a register.
- `imem_rdata_i` in INSTR_W: memory data, valid one cycle after the address.
- `instr_o` out INSTR_W: instruction to the decoder. `16'h0000` whenever `valid_o` = 0.
- `valid_o` out 1: `instr_o` is a real instruction. Downstream gates all write enables with it.
- `pc_o` out ADDR_W: address of `instr_o`.
- `flush_o` out 1: high during the cycle a squashed slot is presented.

## Operation
- Opcode is `instr[15:12]`; the branch opcodes are 8 (je), 9 (jne) and A (jmp).
- Branch taken when any of the following holds:
  - `PcWriteEn[2]`
  - `PcWriteEn[1]` and `zero_i` = 1
  - `PcWriteEn[0]` and `zero_i` = 0
- A redirect is honoured only when `valid_o` = 1 and `stall_i` = 0. In any other cycle `PcWriteEn` is ignored.
- `pc_q` is the next fetch address, and `imem_addr_o = pc_q`.
- `fpc_q` holds the address of the data currently on `imem_rdata_i`.
- PC arithmetic is modulo 2^ADDR_W: 255 + 1 wraps to 0.

State machine (`fetch_state_t`):
- **BOOT**: entered on reset.
  - Outputs: `valid_o` = 0.
  - Next edge: `pc_q <= RESET_PC+1`, go to RUN.
- **RUN**:
  - Outputs: `instr_o = imem_rdata_i`, `pc_o = fpc_q`, `valid_o` = 1.
  - Taken branch: `pc_q <= Immediate`, go to FLUSH.
  - `stall_i` = 1: `hold_q <= imem_rdata_i`, `pc_q` holds, go to STALL.
  - Otherwise: `pc_q <= pc_q+1`.
- **STALL**:
  - Outputs: `instr_o = hold_q`, `pc_o = hold_pc_q`, `valid_o` = 1.
  - `pc_q` holds, so the re-read returns the next instruction.
  - `stall_i` = 0: `pc_q <= pc_q+1`, go to RUN. A branch held in STALL is resolved in the release cycle, taking the redirect path instead.
- **FLUSH**:
  - Outputs: `valid_o` = 0, `flush_o` = 1; the wrong-path data is discarded.
  - Next edge: `pc_q <= pc_q+1`, go to RUN.
  - `stall_i` is ignored.
- Priority: `rst` > redirect > stall > advance.

## Timing
- Reset values: state BOOT, `pc_q = RESET_PC`, `imem_addr_o = RESET_PC`, `instr_o = 0`, `valid_o = 0`, `pc_o = 0`, `flush_o = 0`, `hold_q = 0`.
- Reset asserted mid-stall or mid-flush discards everything; the next cycle is BOOT.
- After reset deasserts:
  - The first valid instruction (`mem[RESET_PC]`) appears one cycle later, after one BOOT cycle.
  - Throughput is then one instruction per cycle.
- Taken branch presented in cycle t:
  - t+1 is the bubble (`valid_o` = 0).
  - t+2 presents `mem[Immediate]` with `pc_o = Immediate`.
  - Penalty: exactly 1 cycle.
- A not-taken je/jne has no penalty.
- Stall of N cycles: `instr_o`/`pc_o` stay constant for N+1 cycles, and the successor appears the cycle after release.
- No combinational path from `zero_i`/`PcWriteEn` to `imem_addr_o`.

## Structure
- Shared package `asip_pkg` holds:
  - `fetch_state_t`
  - opcode constants `OP_JE=4'h8`, `OP_JNE=4'h9`, `OP_JMP=4'hA`
  - `PCWE_JMP=3'b100`, `PCWE_JE=3'b010`, `PCWE_JNE=3'b001`
- One sub-module, `branch_resolve`: combinational taken/target from `PcWriteEn`, `zero_i` and `Immediate`. It is reused by the future execute-stage branch check.
- The hold register and PC logic stay in `fetch_stage`.

## Test plan
Bench uses a 256×16 synchronous memory model with `mem[0]=16'hF510`, `mem[1]=16'hA015`, `mem[2]=16'h1370`, `mem[21]=16'h7E00`, `mem[22]=16'h8010`, `mem[23]=16'h9032`.

- **Reset/boot**: `rst` for 2 cycles, then release.
  - Cycle 1: `valid_o` = 0.
  - Cycle 2: `instr_o = 16'hF510`, `pc_o` = 0.
- **jmp**: `PcWriteEn=3'b100`, `Immediate=21` while `instr_o=16'hA015`.
  - Next cycle: `valid_o` = 0, `flush_o` = 1; `16'h1370` is never valid.
  - Following cycle: `instr_o = 16'h7E00`, `pc_o` = 21.
- **je/jne**:
  - At `pc_o` = 22 with `zero_i` = 0 and `PcWriteEn=3'b010`: no bubble; `pc_o` = 23 next.
  - At 23 with `zero_i` = 0 and `PcWriteEn=3'b001`, `Immediate=50`: bubble, then `pc_o` = 50.
- **Stall**: `stall_i` = 1 for 3 cycles at `pc_o` = 0.
  - `16'hF510` held for 4 cycles.
  - `pc_o` = 1 the cycle after release.
  - `imem_addr_o` constant throughout the stall.
- **Stall+branch**: `stall_i` = 1 with `PcWriteEn=3'b100` at `pc_o` = 1 → no redirect while stalled; the redirect to 21 occurs in the release cycle.
- **Wrap and reset mid-flush**:
  - Run from `RESET_PC=254`: `pc_o` sequence 254, 255, 0.
  - Asserting `rst` during FLUSH: `valid_o` = 0 and `pc_q = RESET_PC` next cycle.
